// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard sequencer: FSM states, forward selects, writeback select.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        REDIRECT   = 2'b10,
        MEM_WAIT   = 2'b11
    } hz_state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Writeback-from-memory code, matching the ctrl_encode_def value used by the datapath.
    localparam logic [1:0] WDSel_FromMEM = 2'b01;

    // A producer can feed a consumer only if it writes a non-x0 register that matches.
    function automatic logic reg_match(input logic [4:0] rd, input logic wr, input logic [4:0] rs);
        return wr && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// ALU operand forward selector: picks EX/MEM, MEM/WB or register file for one source register.
// Latency: purely combinational.
// Backpressure: none.
module fwd_sel
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_wr_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_wr_i,
    output logic [1:0] sel_o
);

    // The younger producer (EX/MEM) wins over the older one (MEM/WB).
    always_comb begin
        sel_o = FWD_RF;
        if (reg_match(mem_rd_i, mem_wr_i, src_i)) begin
            sel_o = FWD_EXMEM;
        end else if (reg_match(wb_rd_i, wb_wr_i, src_i)) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/forward sequencer for the 5-stage pipeline, with saturating perf counters.
// Latency: stall/flush/forward outputs are combinational in the event cycle; counters update next edge.
// Backpressure: dm_ready low holds PC, IF/ID, ID/EX and EX/MEM until ready or timeout release.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_RegWrite,
    input  logic [1:0]       ex_WDSel,
    input  logic [4:0]       mem_rd,
    input  logic             mem_RegWrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_RegWrite,
    input  logic             ex_redirect,
    input  logic             dm_req,
    input  logic             dm_ready,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             stall_ex_mem,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             busy,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [7:0]       TIMEOUT_W = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    hz_state_e        state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic [4:0]       ex_rs1_q, ex_rs2_q;

    logic load_use;
    logic sp_raw, sif_raw, fif_raw, fie_raw, sem_raw, err_raw, redirect_evt;

    assign load_use = ex_RegWrite && (ex_WDSel == WDSel_FromMEM) && (ex_rd != 5'd0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

    // Next-state and raw control outputs; RUN resolves events as redirect > mem wait > load-use.
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        sp_raw       = 1'b0;
        sif_raw      = 1'b0;
        fif_raw      = 1'b0;
        fie_raw      = 1'b0;
        sem_raw      = 1'b0;
        err_raw      = 1'b0;
        redirect_evt = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_redirect) begin
                    fif_raw      = 1'b1;
                    fie_raw      = 1'b1;
                    redirect_evt = 1'b1;
                    state_d      = REDIRECT;
                end else if (dm_req && !dm_ready) begin
                    sp_raw  = 1'b1;
                    sif_raw = 1'b1;
                    sem_raw = 1'b1;
                    wait_d  = 8'd1;
                    state_d = MEM_WAIT;
                end else if (load_use) begin
                    sp_raw  = 1'b1;
                    sif_raw = 1'b1;
                    fie_raw = 1'b1;
                    state_d = LOAD_STALL;
                end
            end
            LOAD_STALL: begin
                state_d = RUN;
            end
            REDIRECT: begin
                // Kill the wrong-path fetch that was already in flight.
                fif_raw = 1'b1;
                state_d = RUN;
            end
            MEM_WAIT: begin
                sp_raw  = 1'b1;
                sif_raw = 1'b1;
                sem_raw = 1'b1;
                if (dm_ready) begin
                    wait_d  = 8'd0;
                    state_d = RUN;
                end else if (wait_q == TIMEOUT_W) begin
                    err_raw = 1'b1;
                    wait_d  = 8'd0;
                    state_d = RUN;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // FSM state and memory wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Saturating performance counters: stalled-PC cycles and accepted redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (sp_raw && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (redirect_evt && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    // Shadow of the ID/EX source registers: bubbles carry x0, frozen while EX/MEM is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rs1_q <= 5'd0;
            ex_rs2_q <= 5'd0;
        end else if (fie_raw) begin
            ex_rs1_q <= 5'd0;
            ex_rs2_q <= 5'd0;
        end else if (!sem_raw) begin
            ex_rs1_q <= id_rs1;
            ex_rs2_q <= id_rs2;
        end
    end

    fwd_sel u_fwd_a (
        .src_i    (ex_rs1_q),
        .mem_rd_i (mem_rd),
        .mem_wr_i (mem_RegWrite),
        .wb_rd_i  (wb_rd),
        .wb_wr_i  (wb_RegWrite),
        .sel_o    (fwd_a)
    );

    fwd_sel u_fwd_b (
        .src_i    (ex_rs2_q),
        .mem_rd_i (mem_rd),
        .mem_wr_i (mem_RegWrite),
        .wb_rd_i  (wb_rd),
        .wb_wr_i  (wb_RegWrite),
        .sel_o    (fwd_b)
    );

    // Reset masks the combinational controls so the pipeline sees a quiet state immediately.
    assign stall_pc     = sp_raw  & ~rst;
    assign stall_if_id  = sif_raw & ~rst;
    assign flush_if_id  = fif_raw & ~rst;
    assign flush_id_ex  = fie_raw & ~rst;
    assign stall_ex_mem = sem_raw & ~rst;
    assign err_timeout  = err_raw & ~rst;
    assign busy         = (state_q != RUN);
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle expected control vectors go through a scoreboard queue.
// Latency: expectations are compared in the same cycle they are driven, mid low phase.
// Backpressure: n/a.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    // Expected vector layout: {sp, sif, fif, fie, sem, busy, err, fwd_a[1:0], fwd_b[1:0]}
    localparam logic [10:0] E_NONE = 11'b000_0000_0000;
    localparam logic [10:0] E_SP   = 11'b100_0000_0000;
    localparam logic [10:0] E_SIF  = 11'b010_0000_0000;
    localparam logic [10:0] E_FIF  = 11'b001_0000_0000;
    localparam logic [10:0] E_FIE  = 11'b000_1000_0000;
    localparam logic [10:0] E_SEM  = 11'b000_0100_0000;
    localparam logic [10:0] E_BSY  = 11'b000_0010_0000;
    localparam logic [10:0] E_ERR  = 11'b000_0001_0000;
    localparam logic [10:0] E_MW   = E_SP | E_SIF | E_SEM;
    localparam logic [10:0] E_LU   = E_SP | E_SIF | E_FIE;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [4:0]       id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic             id_rs1_used, id_rs2_used, ex_RegWrite, mem_RegWrite, wb_RegWrite;
    logic [1:0]       ex_WDSel;
    logic             ex_redirect, dm_req, dm_ready;
    logic             stall_pc, stall_if_id, flush_if_id, flush_id_ex, stall_ex_mem, busy, err_timeout;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic [10:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_stall = 0;
    int          exp_flush = 0;

    wire [10:0] obs = {stall_pc, stall_if_id, flush_if_id, flush_id_ex, stall_ex_mem,
                       busy, err_timeout, fwd_a, fwd_b};

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite), .ex_WDSel(ex_WDSel),
        .mem_rd(mem_rd), .mem_RegWrite(mem_RegWrite), .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite),
        .ex_redirect(ex_redirect), .dm_req(dm_req), .dm_ready(dm_ready),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .stall_ex_mem(stall_ex_mem), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .busy(busy), .err_timeout(err_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] fw(input logic [1:0] a, input logic [1:0] b);
        return {7'b0, a, b};
    endfunction

    task automatic set_idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd = 5'd0; ex_RegWrite = 1'b0; ex_WDSel = 2'b00;
        mem_rd = 5'd0; mem_RegWrite = 1'b0; wb_rd = 5'd0; wb_RegWrite = 1'b0;
        ex_redirect = 1'b0; dm_req = 1'b0; dm_ready = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd);
        ex_RegWrite = 1'b1; ex_WDSel = 2'b01; ex_rd = rd;
    endtask

    // Scoreboard push; the counter model advances from the expected control bits.
    task automatic push_exp(input string nm, input logic [10:0] v);
        exp_q.push_back(v);
        name_q.push_back(nm);
        if (v[10] && exp_stall < CNT_MAX) exp_stall++;
        if (v[8] && v[7] && exp_flush < CNT_MAX) exp_flush++;
    endtask

    // Scoreboard pop: compare the cycle's outputs mid low phase.
    always @(negedge clk) begin
        logic [10:0] v;
        string nm;
        #2;
        if (exp_q.size() > 0) begin
            v  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (obs !== v) begin
                errors++;
                $display("FAIL %s got %b expected %b", nm, obs, v);
            end
        end
    end

    task automatic test_reset();
        set_idle();
        ex_redirect = 1'b1; dm_req = 1'b1; mem_rd = 5'd5; mem_RegWrite = 1'b1;
        #1 rst = 1'b1;
        #2;
        checks++;
        if (obs !== E_NONE) begin errors++; $display("FAIL reset_outputs got %b expected %b", obs, E_NONE); end
        checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            errors++; $display("FAIL reset_counters got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk); #1;
        checks++;
        if (obs !== E_NONE) begin errors++; $display("FAIL reset_hold got %b expected %b", obs, E_NONE); end
        @(negedge clk);
        set_idle();
        rst = 1'b0;
        push_exp("reset_release", E_NONE);
    endtask

    task automatic test_load_use();
        @(negedge clk); set_idle(); set_load(5'd5); id_rs1 = 5'd5; id_rs1_used = 1'b1;
        push_exp("lu_stall", E_LU);
        @(negedge clk); set_idle();
        push_exp("lu_bubble", E_BSY);
        @(negedge clk); set_idle();
        push_exp("lu_run", E_NONE);
        #3;
        checks++;
        if (stall_cnt !== CNT_W'(exp_stall)) begin
            errors++; $display("FAIL lu_stall_cnt got %0d expected %0d", stall_cnt, exp_stall);
        end
        @(negedge clk); set_idle(); set_load(5'd9); id_rs2 = 5'd9; id_rs2_used = 1'b1;
        push_exp("lu_rs2", E_LU);
        @(negedge clk); set_idle();
        push_exp("lu_rs2_bubble", E_BSY);
        @(negedge clk); set_idle(); set_load(5'd0); id_rs1 = 5'd0; id_rs1_used = 1'b1;
        push_exp("lu_x0", E_NONE);
        @(negedge clk); set_idle(); set_load(5'd6); id_rs2 = 5'd6; id_rs2_used = 1'b0;
        push_exp("lu_unused", E_NONE);
        @(negedge clk); set_idle(); ex_RegWrite = 1'b1; ex_WDSel = 2'b00; ex_rd = 5'd6;
        id_rs1 = 5'd6; id_rs1_used = 1'b1;
        push_exp("lu_alu_result", E_NONE);
        @(negedge clk); set_idle();
        push_exp("lu_idle", E_NONE);
    endtask

    task automatic test_forward();
        @(negedge clk); set_idle(); id_rs1 = 5'd3; id_rs2 = 5'd7; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
        push_exp("fw_latch", E_NONE);
        @(negedge clk); mem_rd = 5'd7; mem_RegWrite = 1'b1; wb_rd = 5'd7; wb_RegWrite = 1'b1;
        push_exp("fw_exmem_prio", fw(2'b00, 2'b01));
        @(negedge clk); mem_RegWrite = 1'b0;
        push_exp("fw_memwb", fw(2'b00, 2'b10));
        @(negedge clk); mem_RegWrite = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
        push_exp("fw_x0", fw(2'b00, 2'b00));
        @(negedge clk); mem_rd = 5'd3; wb_rd = 5'd7;
        push_exp("fw_both", fw(2'b01, 2'b10));
        @(negedge clk); mem_rd = 5'd3; wb_rd = 5'd3;
        push_exp("fw_a_prio", fw(2'b01, 2'b00));
        @(negedge clk); set_idle();
        push_exp("fw_idle", E_NONE);
    endtask

    task automatic test_redirect();
        @(negedge clk); set_idle(); id_rs1 = 5'd9;
        push_exp("rd_pre", E_NONE);
        @(negedge clk); ex_redirect = 1'b1; mem_rd = 5'd9; mem_RegWrite = 1'b1;
        push_exp("rd_flush", E_FIF | E_FIE | fw(2'b01, 2'b00));
        @(negedge clk); id_rs1 = 5'd0;
        push_exp("rd_kill_ignores_redirect", E_FIF | E_BSY);
        @(negedge clk); set_idle();
        push_exp("rd_run", E_NONE);
        #3;
        checks++;
        if (flush_cnt !== CNT_W'(exp_flush)) begin
            errors++; $display("FAIL rd_flush_cnt got %0d expected %0d", flush_cnt, exp_flush);
        end
    endtask

    task automatic test_redirect_load_use();
        @(negedge clk); set_idle(); ex_redirect = 1'b1; set_load(5'd5); id_rs1 = 5'd5; id_rs1_used = 1'b1;
        push_exp("rl_redirect_wins", E_FIF | E_FIE);
        @(negedge clk); set_idle();
        push_exp("rl_kill", E_FIF | E_BSY);
        @(negedge clk); set_idle();
        push_exp("rl_run", E_NONE);
        #3;
        checks++;
        if (stall_cnt !== CNT_W'(exp_stall) || flush_cnt !== CNT_W'(exp_flush)) begin
            errors++;
            $display("FAIL rl_counters got %0d/%0d expected %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
        end
    endtask

    task automatic test_mem_wait();
        @(negedge clk); set_idle(); dm_req = 1'b1;
        push_exp("mw_enter", E_MW);
        @(negedge clk);
        push_exp("mw_wait", E_MW | E_BSY);
        @(negedge clk); ex_redirect = 1'b1;
        push_exp("mw_redirect_ignored", E_MW | E_BSY);
        @(negedge clk); ex_redirect = 1'b0; dm_ready = 1'b1;
        push_exp("mw_release", E_MW | E_BSY);
        @(negedge clk); set_idle();
        push_exp("mw_run", E_NONE);
        #3;
        checks++;
        if (stall_cnt !== CNT_W'(exp_stall) || flush_cnt !== CNT_W'(exp_flush)) begin
            errors++;
            $display("FAIL mw_counters got %0d/%0d expected %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
        end
    endtask

    task automatic test_timeout();
        @(negedge clk); set_idle(); dm_req = 1'b1;
        push_exp("to_enter", E_MW);
        for (int i = 1; i <= MEM_TIMEOUT; i++) begin
            @(negedge clk);
            push_exp((i == MEM_TIMEOUT) ? "to_err_pulse" : "to_wait",
                     E_MW | E_BSY | ((i == MEM_TIMEOUT) ? E_ERR : E_NONE));
        end
        @(negedge clk); set_idle();
        push_exp("to_released", E_NONE);
        #3;
        checks++;
        if (stall_cnt !== CNT_W'(exp_stall)) begin
            errors++; $display("FAIL to_stall_cnt_saturate got %0d expected %0d", stall_cnt, exp_stall);
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk); set_idle(); dm_req = 1'b1;
        push_exp("rs_enter", E_MW);
        @(negedge clk);
        push_exp("rs_wait", E_MW | E_BSY);
        @(negedge clk); ex_redirect = 1'b1;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs !== E_NONE) begin errors++; $display("FAIL rs_outputs got %b expected %b", obs, E_NONE); end
        checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            errors++; $display("FAIL rs_counters got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk); #1;
        checks++;
        if (obs !== E_NONE) begin errors++; $display("FAIL rs_hold got %b expected %b", obs, E_NONE); end
        set_idle();
        rst = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        @(negedge clk); set_idle();
        push_exp("rs_no_pending", E_NONE);
        @(negedge clk); dm_req = 1'b1; dm_ready = 1'b1;
        push_exp("rs_ready_same_cycle", E_NONE);
        @(negedge clk); set_idle();
        push_exp("rs_idle", E_NONE);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            @(negedge clk); set_idle(); ex_redirect = 1'b1;
            push_exp("bb_flush", E_FIF | E_FIE);
            @(negedge clk);
            push_exp("bb_kill", E_FIF | E_BSY);
        end
        @(negedge clk); set_idle();
        push_exp("bb_run", E_NONE);
        #3;
        checks++;
        if (flush_cnt !== CNT_W'(exp_flush)) begin
            errors++; $display("FAIL bb_flush_cnt_saturate got %0d expected %0d", flush_cnt, exp_flush);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired at %0t expected completion", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_redirect();
        test_redirect_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        @(negedge clk); #4;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forward sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Inputs:
  - register usage from ID;
  - destination and writeback info from ID/EX, EX/MEM and MEM/WB;
  - the branch/jump redirect request raised in EX;
  - the data-memory ready handshake.
- Outputs:
  - per-stage stall and flush enables;
  - ALU operand forwarding selects;
  - saturating performance counters.
- Replaces the ad-hoc flush register currently held inside the EX stage.

Parameters:
- CNT_W, 16, width of performance counters stall_cnt and flush_cnt.
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before err_timeout is pulsed. Legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_rd  in  5  ID/EX destination register
- ex_RegWrite  in  1  ID/EX writes register
- ex_WDSel  in  2  ID/EX writeback select (WDSel_FromMEM means load)
- mem_rd  in  5  EX/MEM destination register
- mem_RegWrite  in  1  EX/MEM writes register
- wb_rd  in  5  MEM/WB destination register
- wb_RegWrite  in  1  MEM/WB writes register
- ex_redirect  in  1  EX resolved taken branch/jal/jalr this cycle
- dm_req  in  1  MEM stage access (load or store) valid
- dm_ready  in  1  data memory completes access this cycle
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID register
- flush_if_id  out  1  clear IF/ID register to NOP
- flush_id_ex  out  1  clear ID/EX register (bubble)
- stall_ex_mem  out  1  hold ID/EX and EX/MEM registers
- fwd_a  out  2  ALU_A source select
- fwd_b  out  2  ALU_B source select
- busy  out  1  FSM not in RUN
- err_timeout  out  1  one-cycle pulse on MEM_WAIT timeout
- stall_cnt  out  CNT_W  cycles with stall_pc=1, saturating
- flush_cnt  out  CNT_W  redirect events, saturating

Behaviour:
- Reset (async, rst=1):
  - FSM=RUN; wait counter=0; stall_cnt=0; flush_cnt=0; err_timeout=0.
  - All stall/flush outputs 0; fwd_a=fwd_b=00.
  - Outputs follow these values immediately and hold while rst=1.
  - Reset mid-stall discards the stall; no pending event is preserved.
- Forwarding (combinational, registers x0 never forwarded):
  - fwd_x=01 (EX/MEM data) if mem_RegWrite & mem_rd!=0 & mem_rd==ID/EX source.
  - Else fwd_x=10 (MEM/WB data) if wb_RegWrite & wb_rd!=0 & match.
  - Else 00 (register file).
  - EX/MEM has priority over MEM/WB.
  - ID/EX source registers are latched internally from id_rs1/id_rs2 when the ID/EX register advances (not stalled). They are cleared to 0 on flush_id_ex.
- Load-use hazard:
  - Condition: ex_RegWrite & ex_WDSel==WDSel_FromMEM & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- FSM states: RUN, LOAD_STALL, REDIRECT, MEM_WAIT.
- RUN:
  - Event priority: redirect > mem wait > load-use.
  - If ex_redirect: assert flush_if_id and flush_id_ex this cycle; flush_cnt++; next=REDIRECT.
  - Else if dm_req & !dm_ready: assert stall_pc, stall_if_id, stall_ex_mem; next=MEM_WAIT; wait counter=1.
  - Else if load-use: assert stall_pc, stall_if_id, flush_id_ex; next=LOAD_STALL.
- LOAD_STALL:
  - Exactly one bubble was inserted; outputs deasserted; next=RUN.
  - Total latency of a load-use stall is 1 cycle.
- REDIRECT:
  - One cycle with flush_if_id=1 to kill the wrong-path fetch already in flight; next=RUN.
  - A new ex_redirect here is impossible because EX holds a bubble; it is ignored.
- MEM_WAIT:
  - Hold stall_pc, stall_if_id, stall_ex_mem until dm_ready=1. On that cycle, outputs stay asserted, then next=RUN.
  - Each cycle increments the wait counter.
  - When counter==MEM_TIMEOUT: pulse err_timeout; next=RUN (forced release).
  - ex_redirect is ignored in MEM_WAIT; EX is frozen, so it is re-evaluated after release.
- Counters:
  - stall_cnt increments every cycle stall_pc=1.
  - stall_cnt and flush_cnt saturate at all-ones; no wrap.
- Simultaneous events: ex_redirect with load-use: redirect wins. The load instruction in ID/EX has already advanced; the stall is dropped because the dependent instruction is flushed.

Decomposition:
- Shared package/header: FSM state encodings (RUN=2'b00, LOAD_STALL=2'b01, REDIRECT=2'b10, MEM_WAIT=2'b11).
- Shared package/header: forward select encodings (FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10).
- WDSel encodings stay in ctrl_encode_def.
- One sub-module: fwd_sel, a pure-combinational unit, instantiated twice (operands A and B).

Test Plan:
- Load-use: ID/EX load with ex_rd=5, ID rs1=5 used -> cycle N: stall_pc=1 and flush_id_ex=1; cycle N+1: all clear; stall_cnt=1.
- Forward priority: mem_rd=wb_rd=7, both RegWrite, latched rs2=7 -> fwd_b=01. Then mem_RegWrite=0 -> fwd_b=10. Then rd=0 -> fwd_b=00.
- Redirect: ex_redirect pulse at cycle N -> flush_if_id=1 in N and N+1; flush_id_ex=1 only in N; flush_cnt=1.
- Redirect plus load-use in the same cycle -> REDIRECT path taken; stall_pc stays 0; stall_cnt unchanged.
- Memory wait: dm_req=1, dm_ready=0 for 3 cycles then 1 -> stall_pc and stall_ex_mem high for 4 cycles; busy high for 3 cycles; no err_timeout.
- Timeout and reset: dm_ready held 0 with MEM_TIMEOUT=15 -> err_timeout pulse after 15 wait cycles, then RUN. Asserting rst mid-MEM_WAIT -> all outputs 0 immediately, counters 0.
